// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports and the busy scoreboard.
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr0_clr;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     wr1_clr;
  logic                     busy_set_en;
  logic [ADDR_W-1:0]        busy_set_addr;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr0_clr,
           wr1_en, wr1_addr, wr1_data, wr1_clr, busy_set_en, busy_set_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr0_clr,
           wr1_en, wr1_addr, wr1_data, wr1_clr, busy_set_en, busy_set_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with two prioritised write ports, optional
// write-to-read bypass, optional hardwired zero register and a busy scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Writes and clears are suppressed in the reset cycle, including on the bypass path.
  logic wr0_act;
  logic wr1_act;
  assign wr0_act = bus.wr0_en & ~reset;
  assign wr1_act = bus.wr1_en & ~reset;

  assign bus.busy_vec = busy_q;

  // Next-state for storage and busy bits; later assignments carry priority.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr0_act) regs_d[bus.wr0_addr] = bus.wr0_data;
    if (wr1_act) regs_d[bus.wr1_addr] = bus.wr1_data;
    if (wr0_act && bus.wr0_clr) busy_d[bus.wr0_addr] = 1'b0;
    if (wr1_act && bus.wr1_clr) busy_d[bus.wr1_addr] = 1'b0;
    if (bus.busy_set_en) busy_d[bus.busy_set_addr] = 1'b1;
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports: bypass (wr1 over wr0), then zero-register forcing.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rb;
    logic              hit0;
    logic              hit1;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra   = '0;
    rdat = '0;
    rb   = 1'b0;
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
      rdat = regs_q[ra];
      rb   = busy_q[ra];
      hit0 = wr0_act && (bus.wr0_addr == ra);
      hit1 = wr1_act && (bus.wr1_addr == ra);
      if (BYPASS != 0) begin
        if (hit1)      rdat = bus.wr1_data;
        else if (hit0) rdat = bus.wr0_data;
        if ((hit0 && bus.wr0_clr) || (hit1 && bus.wr1_clr)) rb = 1'b0;
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdat = '0;
        rb   = 1'b0;
      end
      bus.rd_data[k*DATA_W +: DATA_W] = rdat;
      bus.rd_busy[k] = rb;
    end
  end

endmodule
